// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the fetch/decode front end: opcodes, funct3 codes,
// ALU control values, the controller state type and a funct3-to-ALU helper.
package riscv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {FETCH, WAIT, EXEC, HALT} state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] ctrl;
  } alu_sel_t;

  // OP and OP-IMM share the same funct3 -> ALU mapping for the supported subset.
  function automatic alu_sel_t aluForFunct3(input logic [2:0] funct3);
    alu_sel_t sel;
    sel.valid = 1'b1;
    sel.ctrl  = ALU_ADD;
    case (funct3)
      F3_ADD:  sel.ctrl = ALU_ADD;
      F3_SLT:  sel.ctrl = ALU_SLT;
      F3_OR:   sel.ctrl = ALU_OR;
      F3_AND:  sel.ctrl = ALU_AND;
      default: sel.valid = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I decoder for the supported OP / OP-IMM / BRANCH subset;
// flags every other encoding as illegal.
module instr_decoder
  import riscv_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int REGWIDTH  = 5
) (
  input  logic [31:0]          instr_i,
  output logic [REGWIDTH-1:0]  rs1_o,
  output logic [REGWIDTH-1:0]  rs2_o,
  output logic [REGWIDTH-1:0]  rd_o,
  output logic                 regWrite_o,
  output logic                 aluSrc_o,
  output logic [2:0]           aluCtrl_o,
  output logic [DATAWIDTH-1:0] immOp_o,
  output logic                 isBranch_o,
  output logic                 isBne_o,
  output logic                 illegal_o
);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [DATAWIDTH-1:0] immI;
  logic [DATAWIDTH-1:0] immB;
  alu_sel_t             aluSel;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign immI   = {{(DATAWIDTH-12){instr_i[31]}}, instr_i[31:20]};
  assign immB   = {{(DATAWIDTH-13){instr_i[31]}}, instr_i[31], instr_i[7],
                   instr_i[30:25], instr_i[11:8], 1'b0};
  assign aluSel = aluForFunct3(funct3);

  always_comb begin
    rs1_o      = instr_i[19:15];
    rs2_o      = instr_i[24:20];
    rd_o       = instr_i[11:7];
    regWrite_o = 1'b0;
    aluSrc_o   = 1'b0;
    aluCtrl_o  = ALU_ADD;
    immOp_o    = immI;
    isBranch_o = 1'b0;
    isBne_o    = 1'b0;
    illegal_o  = 1'b1;
    case (opcode)
      OPC_OP_IMM: begin
        aluSrc_o   = 1'b1;
        aluCtrl_o  = aluSel.ctrl;
        regWrite_o = aluSel.valid;
        illegal_o  = !aluSel.valid;
      end
      OPC_OP: begin
        // funct7[5] is only meaningful on the add/sub slot; anything else is rejected.
        if (funct7 == F7_BASE) begin
          aluCtrl_o  = aluSel.ctrl;
          regWrite_o = aluSel.valid;
          illegal_o  = !aluSel.valid;
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          aluCtrl_o  = ALU_SUB;
          regWrite_o = 1'b1;
          illegal_o  = 1'b0;
        end
      end
      OPC_BRANCH: begin
        aluCtrl_o = ALU_SUB;
        immOp_o   = immB;
        rd_o      = '0;
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          isBranch_o = 1'b1;
          isBne_o    = (funct3 == F3_BNE);
          illegal_o  = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// RV32I front end: fetch FSM over a valid/ready instruction port, instruction
// register, PC with branch resolution from EQ, and gated datapath controls.
module fetch_decode_ctrl
  import riscv_pkg::*;
#(
  parameter int                   DATAWIDTH = 32,
  parameter int                   REGWIDTH  = 5,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [DATAWIDTH-1:0] imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [DATAWIDTH-1:0] imem_rsp_data,
  input  logic                 EQ,
  output logic [REGWIDTH-1:0]  rs1,
  output logic [REGWIDTH-1:0]  rs2,
  output logic [REGWIDTH-1:0]  rd,
  output logic                 RegWrite,
  output logic                 ALUsrc,
  output logic [2:0]           ALUctrl,
  output logic [DATAWIDTH-1:0] ImmOp,
  output logic [DATAWIDTH-1:0] pc,
  output logic                 retire,
  output logic                 illegal
);

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] pc_q, pc_d;
  logic [DATAWIDTH-1:0] instr_q, instr_d;
  logic                 illegal_q, illegal_d;

  logic                 inExec;
  logic                 reqValid;
  logic                 branchTaken;
  logic [DATAWIDTH-1:0] decIn;
  logic [REGWIDTH-1:0]  decRs1, decRs2, decRd;
  logic                 decRegWrite, decAluSrc, decIsBranch, decIsBne, decIllegal;
  logic [2:0]           decAluCtrl;
  logic [DATAWIDTH-1:0] decImm;

  // In WAIT the decoder looks at the arriving word so the HALT decision needs no extra cycle.
  assign decIn = (state_q == WAIT) ? imem_rsp_data : instr_q;

  instr_decoder #(
    .DATAWIDTH (DATAWIDTH),
    .REGWIDTH  (REGWIDTH)
  ) u_decoder (
    .instr_i    (decIn),
    .rs1_o      (decRs1),
    .rs2_o      (decRs2),
    .rd_o       (decRd),
    .regWrite_o (decRegWrite),
    .aluSrc_o   (decAluSrc),
    .aluCtrl_o  (decAluCtrl),
    .immOp_o    (decImm),
    .isBranch_o (decIsBranch),
    .isBne_o    (decIsBne),
    .illegal_o  (decIllegal)
  );

  assign branchTaken = decIsBranch && (decIsBne ? !EQ : EQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    illegal_d = illegal_q;
    reqValid  = 1'b0;
    inExec    = 1'b0;
    case (state_q)
      FETCH: begin
        reqValid = 1'b1;
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_d = imem_rsp_data;
          if (decIllegal) begin
            illegal_d = 1'b1;
            state_d   = HALT;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        inExec  = 1'b1;
        pc_d    = branchTaken ? pc_q + decImm : pc_q + DATAWIDTH'(4);
        state_d = FETCH;
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end

  assign imem_req_valid = reqValid && rst_n;
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign retire         = inExec;
  assign illegal        = illegal_q;
  assign rs1            = inExec ? decRs1 : '0;
  assign rs2            = inExec ? decRs2 : '0;
  assign rd             = inExec ? decRd : '0;
  assign RegWrite       = inExec && decRegWrite;
  assign ALUsrc         = inExec && decAluSrc;
  assign ALUctrl        = inExec ? decAluCtrl : 3'b000;
  assign ImmOp          = inExec ? decImm : '0;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: reset, ALU/branch decode, PC steering,
// fetch stalls, illegal halt and reset during an outstanding fetch.
module tb_fetch_decode_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        EQ;
  logic [4:0]  rs1, rs2, rd;
  logic        RegWrite, ALUsrc;
  logic [2:0]  ALUctrl;
  logic [31:0] ImmOp, pc;
  logic        retire, illegal;

  int checkCount = 0;
  int failCount  = 0;

  fetch_decode_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .EQ             (EQ),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .RegWrite       (RegWrite),
    .ALUsrc         (ALUsrc),
    .ALUctrl        (ALUctrl),
    .ImmOp          (ImmOp),
    .pc             (pc),
    .retire         (retire),
    .illegal        (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Step past the next rising edge, then drive the inputs seen by the following edge.
  task automatic applyStimulus(input logic ready, input logic rspValid, input logic [31:0] data, input logic eq);
    @(posedge clk);
    #1;
    imem_req_ready = ready;
    imem_rsp_valid = rspValid;
    imem_rsp_data  = data;
    EQ             = eq;
  endtask

  // From FETCH: accept the request, answer in WAIT, and stop inside EXEC.
  task automatic fetchToExec(input logic [31:0] data, input logic eq);
    imem_req_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, data, eq);
    checkOutput("wait_req_valid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, eq);
  endtask

  task automatic checkBne();
    checkOutput("bne_regwrite", 32'(RegWrite), 32'd0);
    checkOutput("bne_alusrc", 32'(ALUsrc), 32'd0);
    checkOutput("bne_aluctrl", 32'(ALUctrl), 32'd1);
    checkOutput("bne_imm", ImmOp, 32'hFFFF_FFFC);
    checkOutput("bne_rs1", 32'(rs1), 32'd10);
    checkOutput("bne_rd", 32'(rd), 32'd0);
    checkOutput("bne_retire", 32'(retire), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    EQ = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_regwrite", 32'(RegWrite), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_retire", 32'(retire), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("rel_addr", imem_addr, 32'd0);

    // addi x10,x0,5
    fetchToExec(32'h00500513, 1'b0);
    checkOutput("addi_rs1", 32'(rs1), 32'd0);
    checkOutput("addi_rd", 32'(rd), 32'd10);
    checkOutput("addi_alusrc", 32'(ALUsrc), 32'd1);
    checkOutput("addi_imm", ImmOp, 32'd5);
    checkOutput("addi_aluctrl", 32'(ALUctrl), 32'd0);
    checkOutput("addi_regwrite", 32'(RegWrite), 32'd1);
    checkOutput("addi_retire", 32'(retire), 32'd1);
    checkOutput("addi_pc", pc, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("addi_next_pc", pc, 32'd4);
    checkOutput("fetch_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("fetch_addr", imem_addr, 32'd4);
    checkOutput("fetch_retire", 32'(retire), 32'd0);
    checkOutput("fetch_regwrite", 32'(RegWrite), 32'd0);

    // sub x12,x10,x11
    fetchToExec(32'h40B50633, 1'b0);
    checkOutput("sub_rs1", 32'(rs1), 32'd10);
    checkOutput("sub_rs2", 32'(rs2), 32'd11);
    checkOutput("sub_rd", 32'(rd), 32'd12);
    checkOutput("sub_alusrc", 32'(ALUsrc), 32'd0);
    checkOutput("sub_aluctrl", 32'(ALUctrl), 32'd1);
    checkOutput("sub_regwrite", 32'(RegWrite), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("sub_next_pc", pc, 32'd8);

    // bne x10,x0,-4 with EQ=0: taken
    fetchToExec(32'hFE051EE3, 1'b0);
    checkBne();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("bne_taken_pc", pc, 32'd4);

    // slti x13,x10,-1
    fetchToExec(32'hFFF52693, 1'b0);
    checkOutput("slti_aluctrl", 32'(ALUctrl), 32'd5);
    checkOutput("slti_imm", ImmOp, 32'hFFFF_FFFF);
    checkOutput("slti_rd", 32'(rd), 32'd13);
    checkOutput("slti_alusrc", 32'(ALUsrc), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("slti_next_pc", pc, 32'd8);

    // bne again with EQ=1: not taken
    fetchToExec(32'hFE051EE3, 1'b1);
    checkBne();
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("bne_fall_pc", pc, 32'd12);

    // beq x0,x0,+8 with EQ=1: taken
    fetchToExec(32'h00000463, 1'b1);
    checkOutput("beq_imm", ImmOp, 32'd8);
    checkOutput("beq_regwrite", 32'(RegWrite), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("beq_taken_pc", pc, 32'd20);

    // Fetch stall: ready low three cycles
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd1);
      checkOutput("stall_addr", imem_addr, 32'd20);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    end
    checkOutput("stall4_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("stall4_addr", imem_addr, 32'd20);
    imem_req_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("accept_req_valid", 32'(imem_req_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd0, 1'b0);
    checkOutput("memwait_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("memwait_retire", 32'(retire), 32'd0);

    // All-zero word is illegal -> HALT
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("halt_illegal", 32'(illegal), 32'd1);
      checkOutput("halt_req_valid", 32'(imem_req_valid), 32'd0);
      checkOutput("halt_regwrite", 32'(RegWrite), 32'd0);
      checkOutput("halt_retire", 32'(retire), 32'd0);
      checkOutput("halt_pc", pc, 32'd20);
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    end

    // Reset leaves HALT
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("haltrst_illegal", 32'(illegal), 32'd0);
    checkOutput("haltrst_pc", pc, 32'd0);
    checkOutput("haltrst_req_valid", 32'(imem_req_valid), 32'd0);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("haltrel_req_valid", 32'(imem_req_valid), 32'd1);
    fetchToExec(32'h00500513, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("again_pc", pc, 32'd4);

    // Reset while a fetch is outstanding in WAIT
    imem_req_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("w_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("w_pc", pc, 32'd4);
    rst_n = 1'b0;
    #1;
    checkOutput("wrst_pc", pc, 32'd0);
    checkOutput("wrst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("wrst_retire", 32'(retire), 32'd0);
    checkOutput("wrst_regwrite", 32'(RegWrite), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'd0;
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("late_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("late_addr", imem_addr, 32'd0);
    checkOutput("late_illegal", 32'(illegal), 32'd0);
    fetchToExec(32'h00500513, 1'b0);
    checkOutput("post_retire", 32'(retire), 32'd1);
    checkOutput("post_rd", 32'(rd), 32'd10);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
    checkOutput("post_pc", pc, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
